// File: rtl/expu_sum_acc_if.sv
// Handshake bundle between the exponential unit, the softmax denominator
// accumulator and the normalisation stage: an input beat channel (valid/ready
// with per-lane strobes and a last flag) and an output sum channel.
interface expu_sum_acc_if #(
  parameter int unsigned N_ROWS = 1,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ACC_W  = 32
) ();

  // Input beat channel
  logic                      valid_i;
  logic                      ready_o;
  logic [N_ROWS-1:0]         strb_i;
  logic [N_ROWS*WIDTH-1:0]   op_i;
  logic                      last_i;

  // Output sum channel
  logic [ACC_W-1:0]          sum_o;
  logic                      sum_valid_o;
  logic                      sum_ready_i;

  // Producer of beats / consumer of sums
  modport master (
    output valid_i, strb_i, op_i, last_i, sum_ready_i,
    input  ready_o, sum_o, sum_valid_o
  );

  // The accumulator itself
  modport slave (
    input  valid_i, strb_i, op_i, last_i, sum_ready_i,
    output ready_o, sum_o, sum_valid_o
  );

endinterface

// File: rtl/expu_sum_acc.sv
// Softmax denominator accumulator. Each strobed lane of a beat of non-negative
// floating-point exponentials is converted to unsigned fixed point (stage 1),
// the lanes are summed and accumulated across beats with saturation (stage 2),
// and the final sum is offered to the normalisation stage after a last beat.
//
// FPFORMAT codes: 0 = FP32, 1 = FP16, 2 = BF16 (the exponential unit's
// native input format, used by default).
module expu_sum_acc #(
  parameter int unsigned FPFORMAT = 2,
  parameter int unsigned N_ROWS   = 1,
  parameter int unsigned ACC_INT  = 16,
  parameter int unsigned ACC_FRAC = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  expu_sum_acc_if.slave     bus,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned EXP_BITS = (FPFORMAT == 32'd0) ? 32'd8  :
                                     (FPFORMAT == 32'd1) ? 32'd5  : 32'd8;
  localparam int unsigned MAN_BITS = (FPFORMAT == 32'd0) ? 32'd23 :
                                     (FPFORMAT == 32'd1) ? 32'd10 : 32'd7;
  localparam int unsigned WIDTH    = 32'd1 + EXP_BITS + MAN_BITS;
  localparam int unsigned BIAS     = (32'd1 << (EXP_BITS - 32'd1)) - 32'd1;
  localparam int unsigned ACC_W    = ACC_INT + ACC_FRAC;
  localparam int unsigned TREE_W   = ACC_W + $clog2(N_ROWS);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Convert one lane to {overflow, fixed-point value}. Negative finite values
  // (including -inf) are invalid exponentials and count as zero without
  // flagging; inf, NaN and out-of-range magnitudes saturate and flag.
  function automatic logic [ACC_W:0] f_convert(
    input logic             strb,
    input logic [WIDTH-1:0] op
  );
    logic                s;
    logic [EXP_BITS-1:0] e;
    logic [MAN_BITS-1:0] m;
    logic [MAN_BITS:0]   mant;
    logic [ACC_W-1:0]    val;
    logic [ACC_W:0]      res;
    int                  k;
    s    = op[WIDTH-1];
    e    = op[WIDTH-2 -: EXP_BITS];
    m    = op[MAN_BITS-1:0];
    mant = {1'b1, m};
    val  = '0;
    k    = 0;
    if (!strb || (e == '0)) begin
      res = '0;
    end else if (e == '1) begin
      // NaN always flags; +inf flags; -inf is just a negative value
      if ((m != '0) || !s) begin
        res = {1'b1, {ACC_W{1'b1}}};
      end else begin
        res = '0;
      end
    end else if (s) begin
      res = '0;
    end else if ((int'(e) - int'(BIAS)) >= int'(ACC_INT)) begin
      res = {1'b1, {ACC_W{1'b1}}};
    end else begin
      // k is the left shift that places the hidden-one mantissa at its
      // fixed-point weight; negative k truncates fraction bits away.
      k = int'(e) - int'(BIAS) + int'(ACC_FRAC) - int'(MAN_BITS);
      if (k >= 0) begin
        val = ACC_W'(mant) << k;
      end else begin
        val = ACC_W'(mant >> (-k));
      end
      res = {1'b0, val};
    end
    return res;
  endfunction

  state_e            r_state;
  state_e            w_state_next;
  logic              w_ready;
  logic              w_accept;
  logic              w_handshake;

  logic [ACC_W-1:0]  w_conv [N_ROWS];
  logic              w_lane_ovf;

  logic [ACC_W-1:0]  r_s1_val [N_ROWS];
  logic              r_s1_valid;
  logic              r_s1_last;
  logic              r_s1_ovf;

  logic [TREE_W-1:0] w_tree;
  logic [TREE_W:0]   w_acc_sum;
  logic              w_sat;
  logic [ACC_W-1:0]  w_acc_next;

  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;

  assign w_ready     = enable_i & (r_state == ST_ACCUM);
  assign w_accept    = bus.valid_i & w_ready;
  assign w_handshake = enable_i & (r_state == ST_DONE) & bus.sum_ready_i;

  // Per-lane float-to-fixed conversion and OR of the lane overflow flags
  always_comb begin
    logic [ACC_W:0] w_res;
    w_lane_ovf = 1'b0;
    w_res      = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      w_res      = f_convert(bus.strb_i[i], bus.op_i[i*int'(WIDTH) +: WIDTH]);
      w_conv[i]  = w_res[ACC_W-1:0];
      w_lane_ovf = w_lane_ovf | w_res[ACC_W];
    end
  end

  // Next-state logic: finish a sum after its last beat reaches the accumulator
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && bus.last_i) begin
          w_state_next = ST_FLUSH;
        end else begin
          w_state_next = ST_ACCUM;
        end
      end
      ST_FLUSH: begin
        if (enable_i && r_s1_valid && r_s1_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_DONE: begin
        if (w_handshake) begin
          w_state_next = ST_ACCUM;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
  end

  // State register; clear returns to ACCUM regardless of stall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_ACCUM;
    end else if (clear_i) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stage 1: capture converted lanes of an accepted beat; drop valid on idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_ROWS); i++) r_s1_val[i] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ovf   <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(N_ROWS); i++) r_s1_val[i] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_ovf   <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < int'(N_ROWS); i++) r_s1_val[i] <= w_conv[i];
      r_s1_valid <= 1'b1;
      r_s1_last  <= bus.last_i;
      r_s1_ovf   <= w_lane_ovf;
    end else if (enable_i) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Lane adder tree, wide enough that it cannot wrap
  always_comb begin
    w_tree = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      w_tree = w_tree + TREE_W'(r_s1_val[i]);
    end
  end

  // Accumulate and saturate to the accumulator width
  always_comb begin
    w_acc_sum = (TREE_W + 1)'(r_acc) + (TREE_W + 1)'(w_tree);
    w_sat     = (w_acc_sum[TREE_W:ACC_W] != '0);
    if (w_sat) begin
      w_acc_next = {ACC_W{1'b1}};
    end else begin
      w_acc_next = w_acc_sum[ACC_W-1:0];
    end
  end

  // Stage 2: accumulator and sticky overflow, zeroed when the sum is taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (clear_i) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_handshake) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (enable_i && r_s1_valid) begin
      r_acc <= w_acc_next;
      r_ovf <= r_ovf | r_s1_ovf | w_sat;
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.sum_o       = r_acc;
  assign bus.sum_valid_o = (r_state == ST_DONE);
  assign overflow_o      = r_ovf;
  assign busy_o          = r_s1_valid | (r_state != ST_ACCUM) | (r_acc != '0);

endmodule

// File: doc/expu_sum_acc.md
# expu_sum_acc

Softmax denominator accumulator that sits directly downstream of the exponential unit. It takes vectors of non-negative floating-point exponentials, N_ROWS lanes per beat with per-lane strobes, and converts each strobed lane to unsigned fixed point. It sums the lanes in an adder tree and accumulates the result across beats until a beat flagged `last_i`. It then presents the saturated fixed-point sum to the normalisation stage through a valid/ready handshake.

## Interface
Parameters:
- FPFORMAT, default FPFORMAT_IN: input float format; WIDTH, MAN_BITS, EXP_BITS and BIAS are derived from it.
- N_ROWS, default 1: lanes per beat.
- ACC_INT, default 16: integer bits of the accumulator.
- ACC_FRAC, default 16: fraction bits of the accumulator; ACC_W = ACC_INT + ACC_FRAC.

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of all state
- enable_i  in  1  global stall: when 0, no register updates
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i & ready_o
- strb_i  in  N_ROWS  lane strobes
- op_i  in  N_ROWS×WIDTH  lane operands
- last_i  in  1  final beat of the current sum
- sum_o  out  ACC_W  unsigned fixed-point sum, ACC_FRAC fraction bits
- sum_valid_o  out  1  sum_o valid
- sum_ready_i  in  1  consumer takes sum
- overflow_o  out  1  sticky: saturation or inf/NaN seen in the current sum
- busy_o  out  1  any beat in flight, or a non-zero partial sum pending

## Operation
- FSM states ACCUM, FLUSH, DONE. Reset and clear go to ACCUM.
  - ACCUM -> FLUSH when a beat with last_i is accepted.
  - FLUSH -> DONE after one enabled cycle.
  - DONE -> ACCUM on sum_valid_o & sum_ready_i.
- ready_o = enable_i & (state == ACCUM).
- Stage 1 (conversion register) is written on each accepted beat, one lane at a time, with sign s, exponent e and mantissa m:
  - Strobe low, or e == 0 (zero or denormal): contributes 0.
  - s == 1 with a non-NaN value: contributes 0. Negative exponentials are invalid, so they are treated as zero and do not flag.
  - e == all-ones (inf or NaN): contributes all-ones (ACC_W bits) and sets overflow.
  - e − BIAS ≥ ACC_INT: contributes all-ones and sets overflow.
  - Otherwise: value = ({1,m} << ACC_FRAC) >> (MAN_BITS + BIAS − e), left-shifted instead when the shift amount is negative. Truncate, no rounding. Shift amounts ≥ ACC_W + MAN_BITS give 0.
- Stage 1 also registers valid, last and the lane overflow OR. valid is cleared when no beat is accepted and enable_i = 1.
- Stage 2 (accumulator):
  - Adder tree width is ACC_W + clog2(N_ROWS).
  - acc_next = acc + tree, saturated to 2^ACC_W − 1. Saturation sets overflow.
  - acc and overflow are cleared on the sum handshake (DONE -> ACCUM), on clear_i and on reset.
- sum_o = acc. It is held stable while in DONE.
- A last beat with all strobes low is legal and finalises the current sum, which may be 0.
- clear_i has priority over every other update, in any state.
- Reset mid-sum discards the partial sum with no output.

## Timing
- Reset values: ready_o 0 while enable_i = 0, otherwise 1 (state ACCUM); sum_o 0; sum_valid_o 0; overflow_o 0; busy_o 0.
- Throughput is one beat per cycle in ACCUM.
- Latency, with the last beat accepted at edge t:
  - stage 1 is written at t;
  - acc is final at t+1;
  - sum_valid_o rises after t+1, i.e. 2 enabled cycles.
- ready_o is low during FLUSH and DONE, a minimum of 2 cycles of bubble per sum.
- enable_i = 0 freezes the FSM, stage 1 and acc. ready_o and the sum handshake are ignored while enable_i = 0.
- sum_valid_o stays high in DONE until sum_ready_i, without combinational dependence on sum_ready_i.
- The next beat is accepted in the first cycle after the sum handshake. Its contribution is added to a zeroed acc.

## Test plan
- BF16, N_ROWS=4, ACC_FRAC=16, one last beat of {0x3F80, 0x3F00, 0x3E80, 0x3E00}, strobes 1111 -> sum_o = 0x0001E000 two cycles later; overflow_o 0.
- Same values with strobes 0101 -> 0x00014000. Then a second last beat of {0x3F80, 0, 0, 0} after the handshake -> 0x00010000, confirming acc was zeroed.
- Three beats of {0x4000 (2.0)} in lane 0 only, last on the third, with sum_ready_i held low 5 cycles -> sum_o 0x00060000 held stable and ready_o 0 throughout; accepted on handshake.
- Lane value 0x7F80 (inf), or 0x4780 (65536.0 ≥ 2^ACC_INT) -> sum_o 0xFFFFFFFF, overflow_o 1; cleared after the handshake.
- enable_i dropped for 3 cycles mid-sum, and denormal 0x0001 / negative 0xBF80 lanes mixed with 1.0 lanes -> sum counts only the 1.0 lanes; no state change while disabled.
- clear_i, or rst_ni low, asserted while in FLUSH -> sum_valid_o never rises; a fresh single beat of {0x3F80} then yields 0x00010000.
